// File: rtl/serial_pkg.sv
// Shared definitions for the serializer and the serial sequence detector bench.
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam int SER_WIDTH = 8;

endpackage : serial_pkg

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-entry holding register and frame counter.
// Frames stream back-to-back when the next word is already held at the last bit.
module bit_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic             lsb_first,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy,
  output logic [CNT_W-1:0] frame_count
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  ser_state_t       state, state_nx;
  logic [WIDTH-1:0] hold_data, hold_data_nx;
  logic             hold_lsb, hold_lsb_nx;
  logic             hold_full, hold_full_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic             sh_lsb, sh_lsb_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic [CNT_W-1:0] frame_count_nx;
  logic             ser_out_nx, ser_valid_nx, frame_start_nx, busy_nx, data_ready_nx;

  logic accept, last_bit, load;

  assign accept   = data_valid && data_ready;
  assign last_bit = (state == SHIFT) && (idx == LAST_IDX);
  // A held word is loaded either from idle or straight after the last bit, giving zero gap.
  assign load     = hold_full && ((state == IDLE) || last_bit);

  // NOTE: every signal gets a default before any branch so no path leaves it unassigned and
  // no latch is inferred.
  always_comb begin
    state_nx       = state;
    hold_data_nx   = hold_data;
    hold_lsb_nx    = hold_lsb;
    hold_full_nx   = hold_full;
    shreg_nx       = shreg;
    sh_lsb_nx      = sh_lsb;
    idx_nx         = idx;
    frame_count_nx = frame_count;

    if (state == SHIFT) begin
      idx_nx   = idx + IDX_W'(1);
      shreg_nx = sh_lsb ? (shreg >> 1) : (shreg << 1);
      if (last_bit) begin
        frame_count_nx = frame_count + CNT_W'(1);
        state_nx       = IDLE;
        idx_nx         = '0;
      end
    end

    if (load) begin
      state_nx     = SHIFT;
      shreg_nx     = hold_data;
      sh_lsb_nx    = hold_lsb;
      idx_nx       = '0;
      hold_full_nx = 1'b0;
    end

    // Accept and drain never coincide: data_ready is low whenever hold_full is set.
    if (accept) begin
      hold_data_nx = data_in;
      hold_lsb_nx  = lsb_first;
      hold_full_nx = 1'b1;
    end

    // The current bit always sits at the shifter's outgoing end, so outputs are registered.
    ser_valid_nx   = (state_nx == SHIFT);
    ser_out_nx     = ser_valid_nx && (sh_lsb_nx ? shreg_nx[0] : shreg_nx[WIDTH-1]);
    frame_start_nx = load;
    busy_nx        = ser_valid_nx || hold_full_nx;
    data_ready_nx  = !hold_full_nx;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      hold_full   <= 1'b0;
      idx         <= '0;
      frame_count <= '0;
      data_ready  <= 1'b0;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      hold_full   <= hold_full_nx;
      idx         <= idx_nx;
      frame_count <= frame_count_nx;
      data_ready  <= data_ready_nx;
      ser_out     <= ser_out_nx;
      ser_valid   <= ser_valid_nx;
      frame_start <= frame_start_nx;
      busy        <= busy_nx;
    end
  end

  // NOTE: word and shifter contents are left unreset; they are only observed while
  // hold_full or SHIFT qualifies them, and both of those are reset.
  always_ff @(posedge clk) begin
    hold_data <= hold_data_nx;
    hold_lsb  <= hold_lsb_nx;
    shreg     <= shreg_nx;
    sh_lsb    <= sh_lsb_nx;
  end

endmodule : bit_serializer

// File: doc/bit_serializer.md
# bit_serializer

Upstream feeder for the serial sequence detector. The block accepts parallel words over a valid/ready handshake, buffers one word, and shifts each word out one bit per clock on `ser_out`. `ser_out` drives the detector's single-bit `in`. A one-entry holding register lets consecutive frames stream with no idle cycle between them. The block also counts completed frames.

## Interface
Parameters:
- `WIDTH`, default 8: bits per frame. Must be ≥ 2.
- `CNT_W`, default 16: width of the frame counter.

Ports:
- `clk` in 1: the single clock. All state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `data_in` in WIDTH: parallel word.
- `data_valid` in 1: `data_in` is valid this cycle.
- `data_ready` out 1: registered. A word is accepted on an edge where `data_valid && data_ready`.
- `lsb_first` in 1: bit order. Sampled together with the word at acceptance. 0 = MSB first.
- `ser_out` out 1: serial bit. Feeds the detector `in`.
- `ser_valid` out 1: `ser_out` carries a frame bit this cycle.
- `frame_start` out 1: high during the first bit of each frame.
- `busy` out 1: equals `ser_valid || hold_full`.
- `frame_count` out CNT_W: number of completed frames, modulo 2^CNT_W.

## Operation
- Storage:
  - Holding register: word plus its `lsb_first` bit, with a `hold_full` flag.
  - Shift register, WIDTH bits.
  - Bit index counter, 0..WIDTH-1.
- FSM states:
  - IDLE: `ser_valid` = 0, `ser_out` = 0.
  - SHIFT: one frame bit is presented per cycle.
- IDLE → SHIFT: when `hold_full` = 1. On that edge, load the shifter from the holding register, clear `hold_full`, and set the index to 0.
- In SHIFT, each edge advances the index. `ser_out` is:
  - MSB first: bit WIDTH-1-index.
  - LSB first: bit index.
- At index = WIDTH-1 (last bit), on the edge that ends the bit:
  - `frame_count` increments.
  - If `hold_full` = 1, load the next word and stay in SHIFT. The next frame's first bit follows immediately with no gap.
  - Otherwise, go to IDLE.
- Acceptance: on an edge with `data_valid && data_ready`, `hold_full` is set. An accept can coincide with a holding-register drain only if `data_ready` was 1. Since `data_ready` = !`hold_full`, that case cannot happen, so no conflict resolution is needed.
- `data_ready` is registered and equals the next-state value of !`hold_full`. It has no combinational path from `data_valid`.
- Data and `lsb_first` presented without a handshake are ignored.
- `frame_count` wraps from 2^CNT_W-1 to 0 silently.
- Reset, including mid-frame:
  - The frame in flight is discarded and the holding register is cleared.
  - `frame_count` is not incremented for the aborted frame.

## Timing
- Reset values, held while `rst` = 1:
  - `data_ready` = 0, `ser_out` = 0, `ser_valid` = 0, `frame_start` = 0, `busy` = 0, `frame_count` = 0.
  - State = IDLE.
- `data_ready` rises on the first rising edge after `rst` deasserts.
- Latency: word accepted at edge E0 → first bit valid after E1 → last bit valid from E(WIDTH) to E(WIDTH+1). `frame_count` updates at E(WIDTH+1).
- Throughput: one bit per clock sustained. Back-to-back frames need the next word accepted at least one cycle before the current frame's last bit. WIDTH ≥ 2 guarantees this because `data_ready` re-rises one cycle after the holding register drains.
- `frame_start` is asserted for exactly one cycle, aligned with bit 0 of each frame.
- All outputs are registered.

## Structure
- Shared package `serial_pkg`:
  - State enum `ser_state_t` {IDLE, SHIFT}.
  - Default constant `SER_WIDTH` = 8, also used by the detector bench.
- Single module with no sub-module. The holding register, shifter and index counter are small enough to implement inline.

## Test plan
1. Reset: assert `rst` mid-simulation → all outputs 0 at once. `data_ready` returns to 1 one edge after release.
2. Single word 0xB4, `lsb_first` = 0 → `ser_out` = 1,0,1,1,0,1,0,0 on 8 consecutive cycles. `ser_valid` is high for exactly 8 cycles, `frame_start` on the first only, then `frame_count` = 1.
3. Same word with `lsb_first` = 1 → `ser_out` = 0,0,1,0,1,1,0,1.
4. Back-to-back 0xFF, 0x00, 0xA5 with `data_valid` held high → 24 contiguous `ser_valid` cycles with no gap, then `frame_count` = 3. `data_ready` drops after each accept and rises one cycle after each drain.
5. Reset at bit 4 of a frame with a word also in the holding register → no further bits after release, `frame_count` unchanged at 0, holding register empty (`busy` = 0).
6. Counter wrap with CNT_W = 2: send 5 frames → `frame_count` sequence 1,2,3,0,1.
